// File: rtl/fpu_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_div : multicycle IEEE-754 single-precision divider (din1 / din2),      |
// |           restoring mantissa division, round-to-nearest-even, subnormals.  |
// |           Optional FPU_DIV_FLAGS_EN adds the flags[4:0] exception output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpu_div #(
  parameter logic [31:0] QNAN_PATTERN = 32'hFFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        valid,
  output logic [31:0] result,
  output logic        ready
`ifdef FPU_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIV_INIT,
    S_DIVIDE, S_NORM_1, S_NORM_2, S_ROUND, S_PACK, S_DONE
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a, r_b, r_z;
  logic [23:0]        r_a_m, r_b_m, r_z_m;
  logic signed [9:0]  r_a_e, r_b_e, r_z_e;
  logic               r_z_s, r_g, r_r, r_s;
  logic [25:0]        r_rem;
  logic [26:0]        r_q;
  logic [4:0]         r_cnt;

  logic        w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
  logic        w_special, w_ge;
  logic [31:0] w_spec_res;
  logic [25:0] w_rem_sub;
  logic [24:0] w_inc;

  assign w_a_nan  = (&r_a[30:23]) && (|r_a[22:0]);
  assign w_a_inf  = (&r_a[30:23]) && !(|r_a[22:0]);
  assign w_a_zero = (r_a[30:0] == 31'd0);
  assign w_b_nan  = (&r_b[30:23]) && (|r_b[22:0]);
  assign w_b_inf  = (&r_b[30:23]) && !(|r_b[22:0]);
  assign w_b_zero = (r_b[30:0] == 31'd0);

  // Priority order matters: invalid cases must win over inf/zero results
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = QNAN_PATTERN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero))
      w_spec_res = QNAN_PATTERN;
    else if (w_a_inf || w_b_zero)
      w_spec_res = {r_z_s, 8'hFF, 23'd0};
    else if (w_b_inf || w_a_zero)
      w_spec_res = {r_z_s, 31'd0};
    else
      w_special = 1'b0;
  end

  assign w_ge      = (r_rem >= {2'b00, r_b_m});
  assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_b_m}) : r_rem;
  assign w_inc     = {1'b0, r_z_m} + 25'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;  r_b   <= '0;  r_z   <= '0;
      r_a_m   <= '0;  r_b_m <= '0;  r_z_m <= '0;
      r_a_e   <= '0;  r_b_e <= '0;  r_z_e <= '0;
      r_z_s   <= 1'b0; r_g  <= 1'b0; r_r  <= 1'b0; r_s <= 1'b0;
      r_rem   <= '0;  r_q   <= '0;  r_cnt <= '0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (r_state)
        S_IDLE: if (valid) begin
          r_a     <= din1;
          r_b     <= din2;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_a_m   <= {1'b0, r_a[22:0]};
          r_b_m   <= {1'b0, r_b[22:0]};
          r_a_e   <= (r_a[30:23] == 8'd0) ? -10'sd126 : ($signed({2'b00, r_a[30:23]}) - 10'sd127);
          r_b_e   <= (r_b[30:23] == 8'd0) ? -10'sd126 : ($signed({2'b00, r_b[30:23]}) - 10'sd127);
          r_z_s   <= r_a[31] ^ r_b[31];
          r_state <= S_SPECIAL;
        end
        S_SPECIAL: if (w_special) begin
          r_z     <= w_spec_res;
          r_state <= S_DONE;
        end else begin
          r_a_m[23] <= |r_a[30:23];
          r_b_m[23] <= |r_b[30:23];
          r_state   <= S_NORM_A;
        end
        S_NORM_A: if (!r_a_m[23]) begin
          r_a_m <= r_a_m << 1;
          r_a_e <= r_a_e - 10'sd1;
        end else r_state <= S_NORM_B;
        S_NORM_B: if (!r_b_m[23]) begin
          r_b_m <= r_b_m << 1;
          r_b_e <= r_b_e - 10'sd1;
        end else r_state <= S_DIV_INIT;
        S_DIV_INIT: begin
          r_z_e   <= r_a_e - r_b_e;
          r_rem   <= {2'b00, r_a_m};
          r_q     <= '0;
          r_cnt   <= '0;
          r_state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          r_q   <= {r_q[25:0], w_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd26) r_state <= S_NORM_1;
        end
        // A quotient below 1.0 always has q[25] set, so one shift is enough
        S_NORM_1: if (r_q[26]) begin
          r_z_m   <= r_q[26:3];
          r_g     <= r_q[2];
          r_r     <= r_q[1];
          r_s     <= r_q[0] | (r_rem != 26'd0);
          r_state <= S_NORM_2;
        end else begin
          r_q   <= r_q << 1;
          r_z_e <= r_z_e - 10'sd1;
        end
        S_NORM_2: if (r_z_e < -10'sd126) begin
          r_z_m <= r_z_m >> 1;
          r_g   <= r_z_m[0];
          r_r   <= r_g;
          r_s   <= r_s | r_r;
          r_z_e <= r_z_e + 10'sd1;
        end else r_state <= S_ROUND;
        S_ROUND: begin
          if (r_g && (r_r || r_s || r_z_m[0])) begin
            if (w_inc[24]) begin
              r_z_m <= 24'h800000;
              r_z_e <= r_z_e + 10'sd1;
            end else r_z_m <= w_inc[23:0];
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_z_e > 10'sd127)
            r_z <= {r_z_s, 8'hFF, 23'd0};
          else if ((r_z_e == -10'sd126) && !r_z_m[23])
            r_z <= {r_z_s, 8'd0, r_z_m[22:0]};
          else
            r_z <= {r_z_s, 8'(r_z_e + 10'sd127), r_z_m[22:0]};
          r_state <= S_DONE;
        end
        S_DONE: begin
          result  <= r_z;
          ready   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_DIV_FLAGS_EN
  // Pending flags: {invalid, div_by_zero, overflow, underflow, inexact}
  logic [4:0] r_fl;
  logic       r_tiny;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fl   <= '0;
      r_tiny <= 1'b0;
      flags  <= '0;
    end else begin
      case (r_state)
        S_UNPACK: begin
          r_fl   <= '0;
          r_tiny <= 1'b0;
        end
        S_SPECIAL: begin
          r_fl[4] <= w_special && (w_spec_res == QNAN_PATTERN);
          r_fl[3] <= w_special && w_b_zero && !w_a_zero && !w_a_nan && !w_a_inf;
        end
        S_ROUND: begin
          r_fl[0] <= r_g | r_r | r_s;
          r_tiny  <= (r_z_e == -10'sd126) && !r_z_m[23];
        end
        S_PACK: begin
          if (r_z_e > 10'sd127) begin
            r_fl[2] <= 1'b1;
            r_fl[0] <= 1'b1;
          end
          r_fl[1] <= r_tiny & r_fl[0];
        end
        S_DONE: flags <= r_fl;
        default: ;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_div.sv
`default_nettype none
// Scoreboard bench for fpu_div: directed vectors, expectations queued at issue,
// checked by an independent monitor whenever ready pulses.
module tb_fpu_div;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] din1 = '0, din2 = '0;
  logic [31:0] result;
  logic        ready;
`ifdef FPU_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  fpu_div dut (
    .clk    (clk),
    .reset  (reset),
    .din1   (din1),
    .din2   (din2),
    .valid  (valid),
    .result (result),
`ifdef FPU_DIV_FLAGS_EN
    .flags  (flags),
`endif
    .ready  (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (ready) begin
      chk("ready_pulse_width", {31'd0, prev_ready}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got ready=1 result=%h, required no pulse", result);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
`ifdef FPU_DIV_FLAGS_EN
        chk({e.name, "_flags"}, 32'(flags), 32'(e.fl));
`endif
      end
    end
    prev_ready = ready;
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic [4:0] f, input int lat, input string nm);
    @(negedge clk);
    din1  = a;
    din2  = b;
    valid = 1'b1;
    sb.push_back('{res: r, fl: f, due: cyc + 1 + lat, name: nm});
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no ready within %0d cycles, required ready pulse", nm, n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                     input logic [4:0] f, input int lat, input string nm);
    issue(a, b, r, f, lat, nm);
    wait_drain(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
`ifdef FPU_DIV_FLAGS_EN
    chk("reset_flags", 32'(flags), 32'd0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 37, "t1_6div2");
    run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 38, "t2_1div3");
    run(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 3,  "t3_1div0");
    run(32'h80000000, 32'h00000000, 32'hFFC00000, 5'b10000, 3,  "t3_0div0");
    run(32'h00800000, 32'h40000000, 32'h00400000, 5'b00000, 38, "t4_subn_exact");
    run(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 37, "t4_overflow");
    run(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 3,  "x_div_inf");
    run(32'h7FC00001, 32'h3F800000, 32'hFFC00000, 5'b10000, 3,  "nan_in");
    run(32'h7F800000, 32'h7F800000, 32'hFFC00000, 5'b10000, 3,  "inf_div_inf");
    run(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 3,  "neg_inf_div_x");
    run(32'hC1200000, 32'h40A00000, 32'hC0000000, 5'b00000, 37, "neg10_div5");
    run(32'h00000001, 32'h3F800000, 32'h00000001, 5'b00000, 83, "min_subn_div1");
    run(32'h00000003, 32'h40000000, 32'h00000002, 5'b00011, 82, "subn_round_even");

    // T5: reset aborts an op in flight
    @(negedge clk);
    din1  = 32'h40C00000;
    din2  = 32'h40000000;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_abort_result", result, 32'd0);
    chk("t5_abort_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    run(32'h40000000, 32'h3F800000, 32'h40000000, 5'b00000, 37, "t5_after_reset");

    // T6: valid held high with changing operands while busy
    @(negedge clk);
    din1  = 32'h40C00000;
    din2  = 32'h40000000;
    valid = 1'b1;
    sb.push_back('{res: 32'h40400000, fl: 5'b00000, due: cyc + 1 + 37, name: "t6_held_valid"});
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready) begin
        din1 = 32'h40000000;
        din2 = 32'h3F800000;
        sb.push_back('{res: 32'h40000000, fl: 5'b00000, due: cyc + 1 + 37, name: "t6_next_capture"});
        break;
      end
      din1 = 32'h3F800000 + 32'(k);
      din2 = 32'h41000000 - 32'(k);
    end
    @(negedge clk);
    valid = 1'b0;
    wait_drain("t6");
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
